// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-sequence detector with fill gating, optional overlap
// and a saturating match counter.
module seq_detector_param #(
   parameter int                      PATTERN_LEN = 4,
   parameter logic [PATTERN_LEN-1:0]  PATTERN     = 4'b1011,
   parameter bit                      OVERLAP     = 1'b1,
   parameter int                      CNT_W       = 8,
   localparam int                     FILL_W      = $clog2(PATTERN_LEN + 1)
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              en_i,
   input  logic              w_i,
   output logic              salida_o,
   output logic [CNT_W-1:0]  count_o,
   output logic [FILL_W-1:0] fill_o
);

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);

   logic [PATTERN_LEN-1:0] hist_q, hist_d;
   logic [FILL_W-1:0]      fill_q, fill_d, fill_inc;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   salida_q;
   logic [PATTERN_LEN-1:0] bit_eq;
   logic                   match;

   assign hist_d = {hist_q[PATTERN_LEN-2:0], w_i};

   // Per-bit equality against the target; the match is the AND of all lanes.
   genvar gi;
   generate
      for (gi = 0; gi < PATTERN_LEN; gi++) begin : g_cmp
         assign bit_eq[gi] = hist_d[gi] ~^ PATTERN[gi];
      end
   endgenerate

   always_comb begin
      fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      // Fill gating keeps reset-state zeros in hist from ever completing a pattern.
      match    = (fill_inc == FILL_FULL) && (&bit_eq);
      count_d  = count_q;
      if (match && !(&count_q)) begin
         count_d = count_q + CNT_W'(1);
      end
      fill_d = (match && !OVERLAP) ? '0 : fill_inc;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         hist_q   <= '0;
         fill_q   <= '0;
         count_q  <= '0;
         salida_q <= 1'b0;
      end else if (en_i) begin
         hist_q   <= hist_d;
         fill_q   <= fill_d;
         count_q  <= count_d;
         salida_q <= match;
      end else begin
         salida_q <= 1'b0;
      end
   end

   assign salida_o = salida_q;
   assign count_o  = count_q;
   assign fill_o   = fill_q;

endmodule
